// File: rtl/io_map_pkg.sv
// Register map and shared types for the input-capture peripheral.
package io_map_pkg;

  localparam logic [31:0] IN_DATA_ADDR = 32'd12;
  localparam logic [31:0] IN_EDGE_ADDR = 32'd16;
  localparam logic [31:0] IN_IEN_ADDR  = 32'd20;

  localparam int unsigned IO_W  = 16;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_DATA = 2'd1,
    REG_EDGE = 2'd2,
    REG_IEN  = 2'd3
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    reg_sel_e sel;
    case (addr)
      IN_DATA_ADDR: sel = REG_DATA;
      IN_EDGE_ADDR: sel = REG_EDGE;
      IN_IEN_ADDR:  sel = REG_IEN;
      default:      sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/in_debounce_bit.sv
// One input pin: 2-flop synchronizer, tick-driven agreement counter and debounced level.
module in_debounce_bit
  import io_map_pkg::*;
#(
  parameter int unsigned DB_TICKS = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic pin_i,
  output logic db_o,
  output logic chg_o
);

  localparam logic [CNT_W-1:0] DB_LIM  = CNT_W'(DB_TICKS);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             chg_s;

  // Saturating increment so a stuck disagreement can never wrap back to zero.
  assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    chg_s = 1'b0;
    if (tick_i) begin
      if (sync2_q != db_q) begin
        if (cnt_inc_s == DB_LIM) begin
          db_d  = sync2_q;
          cnt_d = '0;
          chg_s = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end else begin
        cnt_d = '0;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_o  = db_q;
  assign chg_o = chg_s;

endmodule

// File: rtl/in_capture_driver.sv
// Debounced 16-bit input port with sticky edge flags, interrupt mask and a simple
// memory-mapped read/write bus.
module in_capture_driver
  import io_map_pkg::*;
#(
  parameter int unsigned DEBOUNCE_DIV = 1000,
  parameter int unsigned DB_TICKS     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IO_port,
  input  logic [31:0] adress,
  input  logic        MemRead,
  input  logic [1:0]  MemWrite,
  input  logic [31:0] bus_in,
  output logic [31:0] bus_out,
  output logic        irq
);

  localparam logic [15:0] DIV_LAST = 16'(DEBOUNCE_DIV - 1);

  logic [15:0]     presc_q, presc_d;
  logic            tick_s;
  logic [IO_W-1:0] db_s, chg_s;
  logic [IO_W-1:0] edge_q, edge_d;
  logic [IO_W-1:0] ien_q, ien_d;
  logic            irq_q, irq_d;
  logic            wr_s;
  reg_sel_e        sel_s;
  logic            unused_bus_s;

  assign tick_s       = (presc_q == DIV_LAST);
  assign wr_s         = |MemWrite;
  assign sel_s        = decode_addr(adress);
  assign unused_bus_s = ^bus_in[31:16];

  for (genvar i = 0; i < IO_W; i++) begin : g_bit
    in_debounce_bit #(
      .DB_TICKS(DB_TICKS)
    ) u_bit (
      .clk   (clk),
      .rst_n (reset),
      .tick_i(tick_s),
      .pin_i (IO_port[i]),
      .db_o  (db_s[i]),
      .chg_o (chg_s[i])
    );
  end

  // Edge flags: a new debounced transition outranks a simultaneous write-1-to-clear.
  always_comb begin
    presc_d = tick_s ? 16'd0 : (presc_q + 16'd1);
    edge_d  = edge_q | chg_s;
    ien_d   = ien_q;
    irq_d   = |(edge_q & ien_q);
    if (wr_s && (sel_s == REG_EDGE)) begin
      edge_d = (edge_q & ~bus_in[15:0]) | chg_s;
    end else if (wr_s && (sel_s == REG_IEN)) begin
      ien_d = bus_in[15:0];
    end else begin
      ien_d = ien_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= 16'd0;
      edge_q  <= '0;
      ien_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      edge_q  <= edge_d;
      ien_q   <= ien_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    bus_out = 32'd0;
    if (MemRead) begin
      case (sel_s)
        REG_DATA: bus_out = {16'd0, db_s};
        REG_EDGE: bus_out = {16'd0, edge_q};
        REG_IEN:  bus_out = {16'd0, ien_q};
        default:  bus_out = 32'd0;
      endcase
    end else begin
      bus_out = 32'd0;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_in_capture_driver.sv
// Scoreboard bench for in_capture_driver with DEBOUNCE_DIV=4, DB_TICKS=3.
module tb_in_capture_driver;

  logic        clk;
  logic        reset;
  logic [15:0] IO_port;
  logic [31:0] adress;
  logic        MemRead;
  logic [1:0]  MemWrite;
  logic [31:0] bus_in;
  logic [31:0] bus_out;
  logic        irq;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  in_capture_driver #(
    .DEBOUNCE_DIV(4),
    .DB_TICKS    (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .IO_port (IO_port),
    .adress  (adress),
    .MemRead (MemRead),
    .MemWrite(MemWrite),
    .bus_in  (bus_in),
    .bus_out (bus_out),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge: queue the expectation, present the read, pop and compare.
  task automatic expect_read(input string tag, input logic ren, input logic [31:0] addr,
                             input logic [31:0] exp);
    exp_q.push_back(exp);
    MemRead = ren;
    adress  = addr;
    #1;
    check(tag, bus_out, exp_q.pop_front());
    MemRead = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] we);
    MemRead  = 1'b0;
    adress   = addr;
    bus_in   = data;
    MemWrite = we;
    @(negedge clk);
    MemWrite = 2'b00;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int hits;
    int n;
    logic found;

    reset    = 1'b0;
    IO_port  = 16'hFFFF;
    adress   = 32'd0;
    MemRead  = 1'b0;
    MemWrite = 2'b00;
    bus_in   = 32'd0;

    #12;
    expect_read("rst_bus_data", 1'b1, 32'd12, 32'h0000_0000);
    expect_read("rst_bus_edge", 1'b1, 32'd16, 32'h0000_0000);
    check("rst_irq", {31'd0, irq}, 32'd0);

    @(negedge clk);
    reset = 1'b1;
    expect_read("post_rst_data", 1'b1, 32'd12, 32'h0000_0000);
    expect_read("post_rst_ien", 1'b1, 32'd20, 32'h0000_0000);
    wait_cycles(18);
    expect_read("rise_data", 1'b1, 32'd12, 32'h0000_FFFF);
    expect_read("rise_edge", 1'b1, 32'd16, 32'h0000_FFFF);
    check("rise_irq_masked", {31'd0, irq}, 32'd0);
    bus_write(32'd16, 32'h0000_FFFF, 2'b01);
    expect_read("w1c_all", 1'b1, 32'd16, 32'h0000_0000);

    IO_port = 16'h0000;
    wait_cycles(20);
    expect_read("fall_data", 1'b1, 32'd12, 32'h0000_0000);
    expect_read("fall_edge", 1'b1, 32'd16, 32'h0000_FFFF);
    bus_write(32'd16, 32'h0000_FFFF, 2'b01);

    IO_port = 16'h0008;
    wait_cycles(5);
    IO_port = 16'h0000;
    wait_cycles(20);
    expect_read("glitch_data", 1'b1, 32'd12, 32'h0000_0000);
    expect_read("glitch_edge", 1'b1, 32'd16, 32'h0000_0000);

    IO_port = 16'h00F0;
    wait_cycles(20);
    expect_read("nib_data", 1'b1, 32'd12, 32'h0000_00F0);
    expect_read("nib_edge", 1'b1, 32'd16, 32'h0000_00F0);
    bus_write(32'd16, 32'h0000_0030, 2'b01);
    expect_read("w1c_partial", 1'b1, 32'd16, 32'h0000_00C0);
    bus_write(32'd12, 32'h0000_FFFF, 2'b11);
    expect_read("ro_data", 1'b1, 32'd12, 32'h0000_00F0);
    bus_write(32'd24, 32'h0000_FFFF, 2'b01);
    expect_read("unmapped_ien", 1'b1, 32'd20, 32'h0000_0000);
    expect_read("unmapped_rd", 1'b1, 32'd24, 32'h0000_0000);
    expect_read("noread", 1'b0, 32'd12, 32'h0000_0000);
    bus_write(32'd16, 32'h0000_FFFF, 2'b01);

    // Clear bit 0 every cycle: the flag may only survive the one edge where set and clear collide.
    IO_port  = 16'h00F1;
    adress   = 32'd16;
    bus_in   = 32'h0000_0001;
    MemWrite = 2'b01;
    MemRead  = 1'b1;
    hits     = 0;
    repeat (30) begin
      @(negedge clk);
      #1;
      if (bus_out[0]) hits++;
    end
    MemWrite = 2'b00;
    MemRead  = 1'b0;
    check("collision_hits", 32'(hits), 32'd1);
    expect_read("collision_data", 1'b1, 32'd12, 32'h0000_00F1);

    @(negedge clk);
    bus_write(32'd20, 32'hABCD_0001, 2'b10);
    expect_read("ien_rw", 1'b1, 32'd20, 32'h0000_0001);
    IO_port = 16'h00F0;
    wait_cycles(20);
    bus_write(32'd16, 32'h0000_FFFF, 2'b01);
    wait_cycles(2);
    check("irq_idle", {31'd0, irq}, 32'd0);

    IO_port = 16'h00F1;
    found   = 1'b0;
    n       = 0;
    while (!found && n < 40) begin
      @(negedge clk);
      MemRead = 1'b1;
      adress  = 32'd16;
      #1;
      found = bus_out[0];
      n++;
    end
    MemRead = 1'b0;
    check("irq_flag_seen", {31'd0, found}, 32'd1);
    check("irq_lag", {31'd0, irq}, 32'd0);
    @(negedge clk);
    #1;
    check("irq_set", {31'd0, irq}, 32'd1);
    bus_write(32'd16, 32'h0000_0001, 2'b01);
    @(negedge clk);
    #1;
    check("irq_clear", {31'd0, irq}, 32'd0);
    expect_read("irq_edge_cleared", 1'b1, 32'd16, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/in_capture_driver.md
IN_CAPTURE_DRIVER -- requirements
Module: in_capture_driver

Interface
REQ-001 SHALL have parameter DEBOUNCE_DIV, default 1000, meaning clk cycles per debounce tick (range 2..65535).
REQ-002 SHALL have parameter DB_TICKS, default 3, meaning consecutive differing ticks needed to accept a new pin level (range 1..7).
REQ-003 SHALL have port clk  in  1  single system clock, rising-edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port IO_port  in  16  external input pins, asynchronous to clk.
REQ-006 SHALL have port adress  in  32  bus byte address.
REQ-007 SHALL have port MemRead  in  1  bus read strobe.
REQ-008 SHALL have port MemWrite  in  2  bus write strobe; any nonzero bit means write.
REQ-009 SHALL have port bus_in  in  32  bus write data.
REQ-010 SHALL have port bus_out  out  32  bus read data.
REQ-011 SHALL have port irq  out  1  level interrupt request.

Function
REQ-012 SHALL pass each IO_port bit through a 2-flop synchronizer before any other use.
REQ-013 SHALL generate a one-cycle tick every DEBOUNCE_DIV clk cycles from a free-running prescaler.
REQ-014 SHALL keep a per-bit counter that, on each tick, increments when the synchronized bit differs from the debounced bit and clears to 0 when equal.
REQ-015 SHALL update the debounced bit and clear its counter on the tick where its counter reaches DB_TICKS.
REQ-016 SHALL set sticky edge flag bit i for one debounced rise and one debounced fall of bit i.
REQ-017 SHALL map address 32'd12 to IN_DATA (read-only; bits 15:0 = debounced value, 31:16 = 0).
REQ-018 SHALL map address 32'd16 to IN_EDGE (bits 15:0 = sticky edge flags; write-1-to-clear from bus_in[15:0]).
REQ-019 SHALL map address 32'd20 to IN_IEN (read/write interrupt enable mask, bits 15:0).
REQ-020 SHALL drive bus_out combinationally in the same cycle when MemRead=1 and adress matches; otherwise bus_out=0.
REQ-021 SHALL have reads with no side effects.
REQ-022 SHALL ignore writes to IN_DATA and to unmapped addresses.
REQ-023 SHALL let the set win over the clear when an edge flag is set and W1C-cleared in the same cycle.
REQ-024 SHALL drive irq registered, as irq = |(IN_EDGE & IN_IEN) of the previous cycle.
REQ-025 SHALL give a worst-case pin-to-IN_DATA latency of 2 + DEBOUNCE_DIV*(DB_TICKS+1) cycles for a stable pin change.
REQ-026 SHALL not advance any counter when a glitch is shorter than one tick period and is not sampled on a tick.
REQ-027 SHALL wrap the prescaler from DEBOUNCE_DIV-1 to 0.
REQ-028 SHALL saturate per-bit counters (no wrap).

Reset
REQ-029 SHALL, while reset=0, asynchronously force: sync flops, debounced value, per-bit counters, prescaler, IN_EDGE, IN_IEN and irq to 0.
REQ-030 SHALL have bus_out=0 during reset.
REQ-031 SHALL raise no edge flag from reset-time values.
REQ-032 SHALL, on reset mid-debounce, discard pending counts, so that a pin held high through reset needs a full debounce window after release.

Structure
REQ-033 SHALL place address constants (IN_DATA_ADDR=12, IN_EDGE_ADDR=16, IN_IEN_ADDR=20) in shared package io_map_pkg.
REQ-034 SHALL implement the per-bit synchronizer, counter and debounced flop as sub-module in_debounce_bit, instantiated 16 times with a shared tick.

Verification (DEBOUNCE_DIV=4, DB_TICKS=3)
REQ-035 SHALL cover reset: release reset with IO_port=16'hFFFF -> IN_DATA=0 first cycle; after <=2+16 cycles IN_DATA=16'hFFFF, IN_EDGE=16'hFFFF.
REQ-036 SHALL cover glitch rejection: pulse IO_port[3] high for 5 cycles -> IN_DATA[3] stays 0, IN_EDGE=0.
REQ-037 SHALL cover W1C: with IN_EDGE=16'h00F0, write 16'h0030 to addr 16 -> read returns 16'h00C0.
REQ-038 SHALL cover set-vs-clear collision: clear bit 0 in the cycle it is set -> IN_EDGE[0]=1.
REQ-039 SHALL cover the interrupt path: IN_IEN=16'h0001, rise on bit 0 -> irq=1 one cycle after flag sets; W1C bit 0 -> irq=0 next cycle.
REQ-040 SHALL cover bus isolation: MemRead=0 or adress=24 -> bus_out=0; write to addr 12 -> IN_DATA unchanged.
